// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the 16-bit sequential divider.
//   DIV_W       : operand / result width
//   DIV_ITERS   : number of restoring-division iterations per operation
//   div_state_t : controller states IDLE / RUN / DONE
//   abs_val()   : two's-complement magnitude, used only by the signed build
package div_pkg;

  localparam int DIV_W     = 16;
  localparam int DIV_ITERS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // The magnitude of 16'h8000 is 16'h8000, which is still correct when the
  // result is read as an unsigned number.
  function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v);
    return v[DIV_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/sub16_borrow.sv
// sub16_borrow -- 16-bit subtractor with borrow out.
//   i_a, i_b  : operands
//   o_diff    : i_a - i_b (modulo 2^16)
//   o_borrow  : 1 when i_b > i_a
module sub16_borrow
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] i_a,
  input  logic [DIV_W-1:0] i_b,
  output logic [DIV_W-1:0] o_diff,
  output logic             o_borrow
);

  assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/seq_divider16.sv
// seq_divider16 -- restoring sequential divider, one quotient bit per cycle.
//
// Ports:
//   clk, reset_n          : clock (rising edge) and asynchronous active-low reset
//   start                 : request, sampled only in IDLE
//   dividend, divisor     : operands, captured on an accepted start
//   signed_op             : (SEQ_DIV_SIGNED_EN builds only) two's-complement op
//   busy                  : high in RUN and DONE
//   done                  : one-cycle pulse in DONE, results valid
//   quotient, remainder   : registered results, held until the next load
//   div_by_zero           : registered flag for the last operation
//   dbg_state             : current controller state
//
// Handshake: start is a request that is taken only while the controller is
// IDLE (busy=0); it is ignored otherwise. Each accepted request produces
// exactly one done pulse, unless reset intervenes. A normal operation shows
// done in cycle 17 after the accepting edge; a zero divisor shows it in cycle 1.
//
// Configuration macro: SEQ_DIV_SIGNED_EN adds the signed_op input and the
// sign-correction applied when results are loaded.
module seq_divider16
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_t       dbg_state
);

  div_state_t       r_state;
  div_state_t       w_next_state;
  logic [4:0]       r_count;
  logic [DIV_W-1:0] r_rem;
  logic [DIV_W-1:0] r_quo;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_quotient;
  logic [DIV_W-1:0] r_remainder;
  logic             r_dbz;

  logic             w_div_zero;
  logic             w_last;
  logic [DIV_W-1:0] w_shift_rem;
  logic             w_carry;
  logic [DIV_W-1:0] w_diff;
  logic             w_borrow;
  logic             w_fits;
  logic [DIV_W-1:0] w_rem_next;
  logic [DIV_W-1:0] w_quo_next;
  logic [DIV_W-1:0] w_dvd_mag;
  logic [DIV_W-1:0] w_dvs_mag;
  logic [DIV_W-1:0] w_q_final;
  logic [DIV_W-1:0] w_r_final;

  assign w_div_zero = (divisor == '0);
  assign w_last     = (r_count == 5'(DIV_ITERS - 1));

  // Shift {rem,quo} left by one. The bit leaving rem is kept as w_carry: when
  // it is set the 17-bit shifted remainder exceeds any 16-bit divisor, so the
  // subtract always fits and the 16-bit difference is already exact.
  assign w_shift_rem = {r_rem[DIV_W-2:0], r_quo[DIV_W-1]};
  assign w_carry     = r_rem[DIV_W-1];

  sub16_borrow u_sub (
    .i_a      (w_shift_rem),
    .i_b      (r_div),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  assign w_fits     = w_carry | ~w_borrow;
  assign w_rem_next = w_fits ? w_diff : w_shift_rem;
  assign w_quo_next = {r_quo[DIV_W-2:0], w_fits};

`ifdef SEQ_DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_dvd_mag = (signed_op && dividend[DIV_W-1]) ? abs_val(dividend) : dividend;
  assign w_dvs_mag = (signed_op && divisor[DIV_W-1])  ? abs_val(divisor)  : divisor;
  assign w_q_final = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
  assign w_r_final = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == IDLE && start && !w_div_zero) begin
      r_neg_q <= signed_op & (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
      r_neg_r <= signed_op & dividend[DIV_W-1];
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_q_final = w_quo_next;
  assign w_r_final = w_rem_next;
`endif

  // Controller state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = w_div_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_rem   <= '0;
              r_count <= '0;
              r_quo   <= w_dvd_mag;
              r_div   <= w_dvs_mag;
              r_dbz   <= 1'b0;
            end
          end
        end
        RUN: begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= r_count + 5'd1;
          if (w_last) begin
            r_quotient  <= w_q_final;
            r_remainder <= w_r_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: doc/seq_divider16.md
SEQ_DIVIDER16 -- requirements
Module: seq_divider16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; only 16 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  16  numerator; captured on accepted start.
REQ-006 SHALL have port divisor  input  16  denominator; captured on accepted start.
REQ-007 SHALL have port busy  output  1  high in RUN and DONE.
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port quotient  output  16  registered result.
REQ-010 SHALL have port remainder  output  16  registered result.
REQ-011 SHALL have port div_by_zero  output  1  registered flag for the last operation.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE, with count as a 5-bit iteration counter.
REQ-013 SHALL, in IDLE with start=1 and divisor!=0, capture operands, clear the partial remainder and count, and go to RUN.
REQ-014 SHALL, in each RUN cycle, shift {rem,quo} left 1, trial-subtract divisor from rem, keep the difference and set quo LSB=1 if no borrow, else restore and set LSB=0.
REQ-015 SHALL leave RUN after exactly 16 iterations and enter DONE.
REQ-016 SHALL load quotient/remainder on the RUN-to-DONE edge, assert done only in DONE, and return to IDLE next edge.
REQ-017 SHALL give latency: done high in cycle 17 after the start edge.
REQ-018 SHALL, for start with divisor==0, go directly IDLE->DONE, with quotient=16'hFFFF, remainder=dividend, div_by_zero=1, and done in cycle 1.
REQ-019 SHALL clear div_by_zero on any accepted start with divisor!=0.
REQ-020 SHALL ignore start while busy=1; captured operands SHALL be unaffected by input changes after capture.
REQ-021 SHALL hold quotient, remainder and div_by_zero stable from DONE until the next result load.
REQ-022 SHALL accept start asserted in the cycle after DONE (IDLE), allowing back-to-back operations every 18 cycles.

Reset
REQ-023 SHALL, on reset_n low, immediately force IDLE, count=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-024 SHALL, on reset mid-RUN, abandon the operation with no done pulse; the first start after release SHALL behave as a fresh operation.

Configuration
REQ-025 SHALL, with SEQ_DIV_SIGNED_EN defined, add input signed_op (1 bit, captured with operands) for two's-complement division.
REQ-026 SHALL, in signed mode, divide operand magnitudes, negate the quotient when operand signs differ, and give the remainder the dividend's sign, all applied when loading results; latency unchanged.
REQ-027 SHALL, in signed mode, give 16'h8000 / 16'hFFFF -> quotient 16'h8000, remainder 0, and give divide-by-zero the same result as REQ-018.
REQ-028 SHALL, without SEQ_DIV_SIGNED_EN, have no signed_op port and perform unsigned-only division.

Structure
REQ-029 SHALL place the state enum (IDLE/RUN/DONE), DIV_W=16 and DIV_ITERS=16 in shared package div_pkg.
REQ-030 SHALL instantiate sub-module sub16_borrow (16-bit a-b with borrow out) for the trial subtract.

Verification
REQ-031 SHALL cover: 100/7 -> quotient 14, remainder 2, done in cycle 17, div_by_zero=0.
REQ-032 SHALL cover: 16'hFFFF/1 -> quotient 16'hFFFF, remainder 0; then 3/16'hFFFF -> quotient 0, remainder 3.
REQ-033 SHALL cover: 5/0 -> quotient 16'hFFFF, remainder 5, div_by_zero=1, done in cycle 1; then 9/3 -> div_by_zero=0, quotient 3.
REQ-034 SHALL cover: start 50/5, start pulsed again with 7/7 at cycle 8 -> ignored, result quotient 10, remainder 0.
REQ-035 SHALL cover: reset_n low at cycle 6 of 1000/3 -> outputs 0 immediately, no done; then 1000/3 -> quotient 333, remainder 1.
REQ-036 SHALL cover, with SEQ_DIV_SIGNED_EN: -7/2 -> quotient 16'hFFFD, remainder 16'hFFFF; 7/-2 -> quotient 16'hFFFD, remainder 1.
